// File: rtl/timer_counter.sv
// Counting core of the 8-bit timer: TCR-selected PCLK prescaler driving an
// up/down TCNT with load, preset-while-stopped and one-cycle OVF/UDF pulses.
module timer_counter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [DATA_WIDTH-1:0] TCR_reg,
  input  logic [DATA_WIDTH-1:0] TDR_reg,
  input  logic                  TDR_WR_pulse,
  output logic [DATA_WIDTH-1:0] TCNT_Out,
  output logic                  Set_OVF_pulse,
  output logic                  Set_UDF_pulse
);

  localparam int unsigned PSC_W = 4;
  localparam int unsigned CKS_W = 2;

  logic             w_load;
  logic             w_down;
  logic             w_en;
  logic [CKS_W-1:0] w_cks;
  logic             w_unused_tcr;

  assign w_load       = TCR_reg[7];
  assign w_down       = TCR_reg[5];
  assign w_en         = TCR_reg[4];
  assign w_cks        = TCR_reg[1:0];
  assign w_unused_tcr = &{TCR_reg[6], TCR_reg[3:2]};

  logic [PSC_W-1:0]      r_psc;
  logic [CKS_W-1:0]      r_cks;
  logic [DATA_WIDTH-1:0] r_tcnt;
  logic                  r_ovf;
  logic                  r_udf;

  logic [PSC_W-1:0] w_psc_max;
  logic             w_psc_clr;
  logic             w_tick;
  logic             w_preset_stopped;
  logic             w_cnt_max;
  logic             w_cnt_zero;

  // Terminal prescaler value N-1 for divide ratios 2/4/8/16
  always_comb begin
    w_psc_max = PSC_W'(1);
    case (w_cks)
      2'b00:   w_psc_max = PSC_W'(1);
      2'b01:   w_psc_max = PSC_W'(3);
      2'b10:   w_psc_max = PSC_W'(7);
      default: w_psc_max = PSC_W'(15);
    endcase
  end

  // A Cks change restarts the divide so the new ratio is measured from the change
  assign w_psc_clr        = !w_en || w_load || (w_cks != r_cks);
  assign w_tick           = !w_psc_clr && (r_psc == w_psc_max);
  assign w_preset_stopped = TDR_WR_pulse && !w_en && !w_load;
  assign w_cnt_max        = &r_tcnt;
  assign w_cnt_zero       = ~|r_tcnt;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_psc <= '0;
      r_cks <= '0;
    end else begin
      r_cks <= w_cks;
      if (w_psc_clr || w_tick) r_psc <= '0;
      else                     r_psc <= r_psc + PSC_W'(1);
    end
  end

  // Count register and wrap pulses; pulses default low every edge
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_tcnt <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      if (w_load) begin
        r_tcnt <= TDR_reg;
      end else if (w_preset_stopped) begin
        r_tcnt <= TDR_reg;
      end else if (w_tick) begin
        if (w_down) begin
          r_tcnt <= r_tcnt - DATA_WIDTH'(1);
          r_udf  <= w_cnt_zero;
        end else begin
          r_tcnt <= r_tcnt + DATA_WIDTH'(1);
          r_ovf  <= w_cnt_max;
        end
      end
    end
  end

  assign TCNT_Out      = r_tcnt;
  assign Set_OVF_pulse = r_ovf;
  assign Set_UDF_pulse = r_udf;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; outputs sampled 1ns after
// each rising PCLK edge, inputs changed at the same point.
module tb_timer_counter;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [7:0] TCR_reg;
  logic [7:0] TDR_reg;
  logic       TDR_WR_pulse;
  logic [7:0] TCNT_Out;
  logic       Set_OVF_pulse;
  logic       Set_UDF_pulse;

  int total = 0;
  int bad   = 0;

  timer_counter #(.DATA_WIDTH(8)) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .TCR_reg       (TCR_reg),
    .TDR_reg       (TDR_reg),
    .TDR_WR_pulse  (TDR_WR_pulse),
    .TCNT_Out      (TCNT_Out),
    .Set_OVF_pulse (Set_OVF_pulse),
    .Set_UDF_pulse (Set_UDF_pulse)
  );

  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; TCR_reg = 8'hB3; TDR_reg = 8'h77; TDR_WR_pulse = 1'b1;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (TCNT_Out !== 8'h00) begin bad++; $display("FAIL reset_tcnt: got %h want 00", TCNT_Out); end
    total++;
    if ({Set_OVF_pulse, Set_UDF_pulse} !== 2'b00) begin
      bad++; $display("FAIL reset_pulses: got %b want 00", {Set_OVF_pulse, Set_UDF_pulse});
    end
    PRESET = 1'b0; TCR_reg = 8'h00; TDR_WR_pulse = 1'b0;
    step();
    total++;
    if (TCNT_Out !== 8'h00) begin bad++; $display("FAIL reset_release: got %h want 00", TCNT_Out); end
  endtask

  task automatic test_up_overflow();
    logic [7:0] exp_cnt [7] = '{8'hFD, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00};
    logic       exp_ovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    TDR_reg = 8'hFD; TCR_reg = 8'h80;
    step();
    total++;
    if (TCNT_Out !== 8'hFD) begin bad++; $display("FAIL up_load: got %h want fd", TCNT_Out); end
    TCR_reg = 8'h10;
    for (int k = 0; k < 7; k++) begin
      step();
      total++;
      if (TCNT_Out !== exp_cnt[k]) begin
        bad++; $display("FAIL up_cnt[%0d]: got %h want %h", k, TCNT_Out, exp_cnt[k]);
      end
      total++;
      if ({Set_OVF_pulse, Set_UDF_pulse} !== {exp_ovf[k], 1'b0}) begin
        bad++; $display("FAIL up_pulse[%0d]: got ovf/udf %b want %b", k,
                        {Set_OVF_pulse, Set_UDF_pulse}, {exp_ovf[k], 1'b0});
      end
    end
  endtask

  task automatic test_down_underflow();
    logic [7:0] exp_cnt;
    TDR_reg = 8'h02; TCR_reg = 8'h81;
    step();
    total++;
    if (TCNT_Out !== 8'h02) begin bad++; $display("FAIL dn_load: got %h want 02", TCNT_Out); end
    TCR_reg = 8'h31;
    for (int k = 0; k < 13; k++) begin
      step();
      exp_cnt = (k < 3) ? 8'h02 : (k < 7) ? 8'h01 : (k < 11) ? 8'h00 : 8'hFF;
      total++;
      if (TCNT_Out !== exp_cnt) begin
        bad++; $display("FAIL dn_cnt[%0d]: got %h want %h", k, TCNT_Out, exp_cnt);
      end
      total++;
      if ({Set_OVF_pulse, Set_UDF_pulse} !== {1'b0, (k == 11)}) begin
        bad++; $display("FAIL dn_pulse[%0d]: got ovf/udf %b want %b", k,
                        {Set_OVF_pulse, Set_UDF_pulse}, {1'b0, (k == 11)});
      end
    end
  endtask

  task automatic test_prescaler();
    logic [7:0] exp_cnt;
    TDR_reg = 8'h00; TCR_reg = 8'h82;
    step();
    TCR_reg = 8'h12;
    for (int k = 0; k < 53; k++) begin
      if (k == 20) TCR_reg = 8'h13;
      step();
      exp_cnt = 8'((k >= 7) + (k >= 15) + (k >= 36) + (k >= 52));
      total++;
      if (TCNT_Out !== exp_cnt) begin
        bad++; $display("FAIL psc_cnt[%0d]: got %h want %h", k, TCNT_Out, exp_cnt);
      end
    end
    total++;
    if ({Set_OVF_pulse, Set_UDF_pulse} !== 2'b00) begin
      bad++; $display("FAIL psc_pulses: got %b want 00", {Set_OVF_pulse, Set_UDF_pulse});
    end
  endtask

  task automatic test_preset_stopped();
    TCR_reg = 8'h00; TDR_reg = 8'h55; TDR_WR_pulse = 1'b1;
    step();
    total++;
    if (TCNT_Out !== 8'h55) begin bad++; $display("FAIL preset_stop: got %h want 55", TCNT_Out); end
    TDR_WR_pulse = 1'b0; TDR_reg = 8'h33;
    step();
    total++;
    if (TCNT_Out !== 8'h55) begin bad++; $display("FAIL preset_nopulse: got %h want 55", TCNT_Out); end
    TCR_reg = 8'h10; TDR_reg = 8'hAA; TDR_WR_pulse = 1'b1;
    step();
    TDR_WR_pulse = 1'b0;
    total++;
    if (TCNT_Out !== 8'h55) begin bad++; $display("FAIL preset_running: got %h want 55", TCNT_Out); end
    step();
    total++;
    if (TCNT_Out !== 8'h56) begin bad++; $display("FAIL preset_run_tick: got %h want 56", TCNT_Out); end
  endtask

  task automatic test_dir_switch();
    logic [7:0] exp_cnt [5] = '{8'h10, 8'h11, 8'h11, 8'h10, 8'h10};
    TDR_reg = 8'h10; TCR_reg = 8'h80;
    step();
    TCR_reg = 8'h10;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) TCR_reg = 8'h30;
      step();
      total++;
      if (TCNT_Out !== exp_cnt[k]) begin
        bad++; $display("FAIL dir_cnt[%0d]: got %h want %h", k, TCNT_Out, exp_cnt[k]);
      end
    end
    step();
    total++;
    if (TCNT_Out !== 8'h0F) begin bad++; $display("FAIL dir_next: got %h want 0f", TCNT_Out); end
  endtask

  task automatic test_reset_midcount();
    TDR_reg = 8'hFF; TCR_reg = 8'h80;
    step();
    TCR_reg = 8'h10;
    step();
    total++;
    if (TCNT_Out !== 8'hFF) begin bad++; $display("FAIL mid_pre: got %h want ff", TCNT_Out); end
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    total++;
    if (TCNT_Out !== 8'h00) begin bad++; $display("FAIL mid_rst_cnt: got %h want 00", TCNT_Out); end
    total++;
    if (Set_OVF_pulse !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf: got %b want 0", Set_OVF_pulse); end
    step();
    total++;
    if (TCNT_Out !== 8'h00) begin bad++; $display("FAIL mid_resume0: got %h want 00", TCNT_Out); end
    step();
    total++;
    if (TCNT_Out !== 8'h01) begin bad++; $display("FAIL mid_resume1: got %h want 01", TCNT_Out); end
    total++;
    if (Set_OVF_pulse !== 1'b0) begin bad++; $display("FAIL mid_resume_ovf: got %b want 0", Set_OVF_pulse); end
  endtask

  initial begin
    PRESET = 1'b1; TCR_reg = 8'h00; TDR_reg = 8'h00; TDR_WR_pulse = 1'b0;
    test_reset();
    test_up_overflow();
    test_down_underflow();
    test_prescaler();
    test_preset_stopped();
    test_dir_switch();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
